cube_move_sequencer: RTL and testbench

- Sequences single cube-face turns for the six-stepper cube robot, one move at a time.
- Accepts move commands over a valid/ready handshake.
- Paces the step pulses with an internal, restartable tick divider (100 Hz at the 25 MHz system clock).
- Drives per-motor step/dir/enable lines and reports completion or abort to the upstream solver-playback logic.

---
 rtl/rbot_motor_pkg.sv | 30 +++
 rtl/cube_move_sequencer_tick_gen.sv | 31 +++
 rtl/cube_move_sequencer.sv | 159 +++++++++++++++
 tb/tb_cube_move_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbot_motor_pkg.sv
// Shared types and constants for the cube robot motor path.
// Faces, directions and the move sequencer state encoding.
package rbot_motor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP_HI,
    STEP_LO,
    SETTLE
  } state_t;

  localparam logic [2:0] FACE_U = 3'd0;
  localparam logic [2:0] FACE_D = 3'd1;
  localparam logic [2:0] FACE_L = 3'd2;
  localparam logic [2:0] FACE_R = 3'd3;
  localparam logic [2:0] FACE_F = 3'd4;
  localparam logic [2:0] FACE_B = 3'd5;
  localparam logic [2:0] NUM_FACES = 3'd6;

  localparam logic DIR_CW = 1'b1;

  // one-hot motor select; illegal faces shift out to zero
  function automatic logic [5:0] face_mask(
    input logic [2:0] f
  );
    return 6'b000001 << f;
  endfunction

endpackage

// File: rtl/cube_move_sequencer_tick_gen.sv
// Restartable tick strobe divider for step pacing.
// Counts while run is high; clear forces the count to zero.
module tick_gen #(
  parameter int TICK_DIV = 250000,
  parameter int CNT_W    = 18
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // free-running divider that wraps on the last count
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      cnt <= '0;
    end else if (run) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cube_move_sequencer.sv
// Single-move sequencer for the six-stepper cube robot.
// Turns one face per command, paced by tick_gen.
module cube_move_sequencer
  import rbot_motor_pkg::*;
#(
  parameter int TICK_DIV          = 250000,
  parameter int STEPS_PER_QUARTER = 50,
  parameter int SETTLE_TICKS      = 10,
  parameter int CNT_W             = 18
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_face,
  input  logic       cmd_dir,
  input  logic       cmd_half,
  input  logic       abort,
  output logic [5:0] step,
  output logic [5:0] dir,
  output logic [5:0] enable,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       aborted
);

  localparam int REM_W =
    $clog2(2 * STEPS_PER_QUARTER + 1);
  localparam int SET_W =
    $clog2(SETTLE_TICKS + 2);

  localparam logic [REM_W-1:0] REM_Q =
    REM_W'(STEPS_PER_QUARTER);
  localparam logic [REM_W-1:0] REM_H =
    REM_W'(2 * STEPS_PER_QUARTER);
  localparam logic [REM_W-1:0] REM_1 =
    REM_W'(1);
  localparam logic [SET_W-1:0] SET_N =
    SET_W'(SETTLE_TICKS);
  localparam logic [SET_W-1:0] SET_1 =
    SET_W'(1);

  state_t           state;
  logic [5:0]       mask;
  logic [REM_W-1:0] remaining;
  logic [SET_W-1:0] settle;
  logic             tick;
  logic             accept;
  logic             legal;
  logic             in_idle;

  assign in_idle   = (state == IDLE);
  assign cmd_ready = in_idle && reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = (cmd_face < NUM_FACES);

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (in_idle),
    .run     (!in_idle),
    .tick    (tick)
  );

  // move FSM with registered motor and status outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      mask      <= '0;
      remaining <= '0;
      settle    <= '0;
      step      <= '0;
      dir       <= '0;
      enable    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      if (!in_idle && abort) begin
        state   <= IDLE;
        step    <= '0;
        dir     <= '0;
        enable  <= '0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept && legal) begin
              state  <= SETUP;
              mask   <= face_mask(cmd_face);
              enable <= face_mask(cmd_face);
              dir    <= (cmd_dir == DIR_CW)
                        ? face_mask(cmd_face)
                        : '0;
              remaining <= cmd_half ? REM_H
                                    : REM_Q;
              busy   <= 1'b1;
            end else if (accept) begin
              err <= 1'b1;
            end
          end
          SETUP: begin
            if (tick) begin
              state <= STEP_HI;
              step  <= mask;
            end
          end
          STEP_HI: begin
            if (tick) begin
              state <= STEP_LO;
              step  <= '0;
            end
          end
          STEP_LO: begin
            if (tick) begin
              remaining <= remaining - 1'b1;
              if (remaining != REM_1) begin
                state <= STEP_HI;
                step  <= mask;
              end else if (SETTLE_TICKS == 0) begin
                state  <= IDLE;
                enable <= '0;
                dir    <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                state  <= SETTLE;
                settle <= SET_N;
              end
            end
          end
          SETTLE: begin
            if (tick) begin
              settle <= settle - 1'b1;
              if (settle == SET_1) begin
                state  <= IDLE;
                enable <= '0;
                dir    <= '0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Self-checking bench for cube_move_sequencer.
// Scoreboard of expected move outcomes plus corner sequences.
module tb_cube_move_sequencer;

  localparam int TD  = 4;
  localparam int SPQ = 3;
  localparam int ST  = 2;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_ABT  = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_face = 3'd0;
  logic       cmd_dir = 1'b0;
  logic       cmd_half = 1'b0;
  logic       abort = 1'b0;
  logic       cmd_ready;
  logic [5:0] step;
  logic [5:0] dir;
  logic [5:0] enable;
  logic       busy;
  logic       done;
  logic       err;
  logic       aborted;

  int total = 0;
  int bad = 0;

  typedef struct {
    int         kind;
    logic [2:0] face;
    logic       dir;
    int         steps;
    int         busy;
  } exp_t;

  typedef struct {
    logic [2:0] face;
    logic       dir;
    logic       half;
    int         kind;
    int         steps;
    int         busy;
  } vec_t;

  exp_t sb[$];

  logic [2:0] mon_face = 3'd0;
  logic       mon_dir = 1'b0;
  int         n_busy, n_en, n_hi, n_rise;
  int         first_rise, last_rise;
  logic       other, dirbad;
  logic [5:0] prev_step = '0;

  cube_move_sequencer #(
    .TICK_DIV          (TD),
    .STEPS_PER_QUARTER (SPQ),
    .SETTLE_TICKS      (ST),
    .CNT_W             (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_face  (cmd_face),
    .cmd_dir   (cmd_dir),
    .cmd_half  (cmd_half),
    .abort     (abort),
    .step      (step),
    .dir       (dir),
    .enable    (enable),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .aborted   (aborted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  task automatic clr_mon();
    n_busy = 0;
    n_en = 0;
    n_hi = 0;
    n_rise = 0;
    first_rise = 0;
    last_rise = 0;
    other = 1'b0;
    dirbad = 1'b0;
  endtask

  // per-cycle observer; pops the scoreboard on any pulse
  task automatic mon();
    logic [2:0] f;
    logic       d;
    logic [5:0] m;
    exp_t       e;
    int         k;
    if (sb.size() > 0) begin
      f = sb[0].face;
      d = sb[0].dir;
    end else begin
      f = mon_face;
      d = mon_dir;
    end
    m = 6'b000001 << f;
    if (!reset_n) begin
      clr_mon();
    end else begin
      if (busy) n_busy++;
      if ((enable & m) != 0) n_en++;
      if ((step & m) != 0) begin
        n_hi++;
        if ((prev_step & m) == 0) begin
          n_rise++;
          if (n_rise == 1) first_rise = n_busy;
          last_rise = n_busy;
        end
      end
      if (((step | enable | dir) & ~m) != 0)
        other = 1'b1;
      if ((enable & m) != 0 &&
          (((dir & m) != 0) != d))
        dirbad = 1'b1;
      if (done || err || aborted) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse",
              {done, err, aborted}, 0);
        end else begin
          e = sb.pop_front();
          k = done ? K_DONE
                   : (err ? K_ERR : K_ABT);
          chk("pulse_kind", k, e.kind);
          chk("pulse_count", int'(done) +
              int'(err) + int'(aborted), 1);
          chk("outs_cleared",
              step | enable | dir, 0);
          chk("busy_at_end", busy, 0);
          chk("busy_cycles", n_busy, e.busy);
          chk("step_pulses", n_rise, e.steps);
          chk("other_motor", other, 0);
          chk("dir_value", dirbad, 0);
          if (e.kind == K_DONE) begin
            chk("enable_cycles", n_en, e.busy);
            chk("step_hi_cycles", n_hi,
                e.steps * TD);
            chk("first_rise", first_rise, TD + 1);
            chk("rise_spacing",
                last_rise - first_rise,
                (e.steps - 1) * 2 * TD);
            chk("ready_on_done", cmd_ready, 1);
          end
          clr_mon();
        end
      end
    end
    prev_step = step;
  endtask

  task automatic cyc();
    @(negedge clock);
    mon();
  endtask

  task automatic send(input logic [2:0] f,
                      input logic d,
                      input logic h,
                      input logic push,
                      input int kind,
                      input int steps,
                      input int bsy);
    int   k;
    exp_t e;
    k = 0;
    while (!cmd_ready && k < 200) begin
      cyc();
      k++;
    end
    chk("ready_wait", cmd_ready, 1);
    if (push) begin
      e.kind = kind;
      e.face = f;
      e.dir = d;
      e.steps = steps;
      e.busy = bsy;
      sb.push_back(e);
    end
    mon_face = f;
    mon_dir = d;
    cmd_face = f;
    cmd_dir = d;
    cmd_half = h;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while (sb.size() != 0 && k < lim) begin
      cyc();
      k++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    vec_t vt[6];
    exp_t e;
    int   k;
    vt[0] = '{3'd2, 1'b1, 1'b0, K_DONE, 3, 36};
    vt[1] = '{3'd5, 1'b0, 1'b1, K_DONE, 6, 60};
    vt[2] = '{3'd6, 1'b1, 1'b0, K_ERR, 0, 0};
    vt[3] = '{3'd3, 1'b0, 1'b0, K_DONE, 3, 36};
    vt[4] = '{3'd7, 1'b0, 1'b1, K_ERR, 0, 0};
    vt[5] = '{3'd4, 1'b1, 1'b1, K_DONE, 6, 60};
    clr_mon();

    reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_ready", cmd_ready, 0);
    chk("rst_outs", {step, dir, enable}, 0);
    chk("rst_flags",
        {busy, done, err, aborted}, 0);
    reset_n = 1'b1;
    cyc();
    chk("ready_after_rst", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      send(vt[i].face, vt[i].dir, vt[i].half,
           1'b1, vt[i].kind, vt[i].steps,
           vt[i].busy);
      chk("ready_after_accept", cmd_ready,
          int'(vt[i].kind == K_ERR));
      chk("busy_after_accept", busy,
          int'(vt[i].kind != K_ERR));
      drain(200);
    end

    send(3'd0, 1'b1, 1'b0, 1'b1, K_ABT, 2, 13);
    k = 0;
    while (n_rise != 2 && k < 100) begin
      cyc();
      k++;
    end
    chk("reach_hi2", n_rise, 2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_popped", sb.size(), 0);
    repeat (10) cyc();
    abort = 1'b1;
    repeat (2) cyc();
    abort = 1'b0;
    chk("idle_abort_ready", cmd_ready, 1);
    send(3'd1, 1'b0, 1'b0, 1'b1, K_DONE, 3, 36);
    drain(200);

    e = '{K_DONE, 3'd4, 1'b1, 3, 36};
    sb.push_back(e);
    mon_face = 3'd4;
    mon_dir = 1'b1;
    cmd_face = 3'd4;
    cmd_dir = 1'b1;
    cmd_half = 1'b0;
    cmd_valid = 1'b1;
    cyc();
    chk("b2b_ready_drop", cmd_ready, 0);
    cmd_face = 3'd3;
    cmd_dir = 1'b0;
    cmd_half = 1'b1;
    repeat (5) cyc();
    cmd_face = 3'd1;
    cmd_dir = 1'b0;
    cmd_half = 1'b0;
    e = '{K_DONE, 3'd1, 1'b0, 3, 36};
    sb.push_back(e);
    k = 0;
    while (!done && k < 100) begin
      cyc();
      k++;
    end
    chk("b2b_done", done, 1);
    chk("b2b_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    chk("b2b_setup_busy", busy, 1);
    chk("b2b_setup_en", enable, 6'b000010);
    chk("b2b_setup_step", step, 0);
    drain(200);

    send(3'd2, 1'b1, 1'b0, 1'b0, K_DONE, 0, 0);
    k = 0;
    while (!(n_rise == 1 && step[2] == 1'b0)
           && k < 100) begin
      cyc();
      k++;
    end
    chk("reach_step_lo", n_rise, 1);
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_outs", {step, dir, enable}, 0);
    chk("mid_rst_flags",
        {busy, done, err, aborted}, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    reset_n = 1'b1;
    cyc();
    chk("rel_ready", cmd_ready, 1);
    repeat (20) cyc();
    chk("queue_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
